// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared paddle channel state and direction encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Per-channel motion state
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLOW  = 2'd1;
    localparam logic [1:0] ST_FAST  = 2'd2;
    localparam logic [1:0] ST_AUTO  = 2'd3;

    // Requested / latched direction of travel
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DN   = 2'd2;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/paddle_pos_chan.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_pos_chan
//  Description : One paddle channel: direction decode, FSM, step divider,
//                acceleration step counter and position clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_pos_chan
    import pong_pkg::*;
#(
    parameter int POS_W       = 11,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 380,
    parameter int ORIGIN      = 190,
    parameter int SLOW_DIV    = 250000,
    parameter int FAST_DIV    = 62500,
    parameter int ACCEL_STEPS = 16,
    parameter int AUTO_DIV    = 125000,
    parameter int DEADBAND    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_up,
    input  logic             i_dn,
    input  logic             i_auto,
    input  logic [POS_W-1:0] i_target,
    input  logic             i_center,
    output logic [POS_W-1:0] o_pos,
    output logic             o_at_min,
    output logic             o_at_max,
    output logic             o_moving
);

    // FAST_DIV never exceeds SLOW_DIV, so the divider only has to span the
    // larger of the slow and auto periods.
    localparam int DIV_MAX = (SLOW_DIV > AUTO_DIV) ? SLOW_DIV : AUTO_DIV;
    localparam int DIV_W   = $clog2(DIV_MAX);
    localparam int STEP_W  = $clog2(ACCEL_STEPS + 1);

    localparam logic [DIV_W-1:0]  c_slow_top  = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0]  c_fast_top  = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0]  c_auto_top  = DIV_W'(AUTO_DIV - 1);
    localparam logic [STEP_W-1:0] c_accel_top = STEP_W'(ACCEL_STEPS - 1);
    localparam logic [POS_W-1:0]  c_pos_min   = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0]  c_pos_max   = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]  c_origin    = POS_W'(ORIGIN);
    localparam logic [POS_W:0]    c_min_x     = (POS_W+1)'(POS_MIN);
    localparam logic [POS_W:0]    c_max_x     = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]    c_db_x      = (POS_W+1)'(DEADBAND);

    logic [1:0]        state_q, state_d;
    logic [1:0]        dir_q,   dir_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [POS_W-1:0]  pos_q,   pos_d;

    logic [POS_W:0]    w_target_x;
    logic [POS_W:0]    w_tgt_x;
    logic [POS_W:0]    w_pos_x;
    logic [1:0]        w_dir;
    logic [DIV_W-1:0]  w_div_top;
    logic              w_same_run;
    logic [POS_W-1:0]  w_pos_step;

    // Decode the requested direction from switches or the clamped target
    always_comb begin
        w_target_x = {1'b0, i_target};
        w_pos_x    = {1'b0, pos_q};
        if (w_target_x < c_min_x) begin
            w_tgt_x = c_min_x;
        end else if (w_target_x > c_max_x) begin
            w_tgt_x = c_max_x;
        end else begin
            w_tgt_x = w_target_x;
        end
        w_dir = DIR_NONE;
        if (i_auto) begin
            if (w_tgt_x > w_pos_x + c_db_x) begin
                w_dir = DIR_UP;
            end else if (w_tgt_x + c_db_x < w_pos_x) begin
                w_dir = DIR_DN;
            end
        end else if (i_up && !i_dn) begin
            w_dir = DIR_UP;
        end else if (i_dn && !i_up) begin
            w_dir = DIR_DN;
        end
    end

    // Divider period for the current state and the clamped next position
    always_comb begin
        w_div_top = c_slow_top;
        if (state_q == ST_FAST) begin
            w_div_top = c_fast_top;
        end else if (state_q == ST_AUTO) begin
            w_div_top = c_auto_top;
        end
        w_pos_step = pos_q;
        if (dir_q == DIR_UP && pos_q != c_pos_max) begin
            w_pos_step = pos_q + POS_W'(1);
        end else if (dir_q == DIR_DN && pos_q != c_pos_min) begin
            w_pos_step = pos_q - POS_W'(1);
        end
        // A run continues only with the same direction in the same mode
        if (i_auto) begin
            w_same_run = (w_dir == dir_q) && (state_q == ST_AUTO);
        end else begin
            w_same_run = (w_dir == dir_q) &&
                         ((state_q == ST_SLOW) || (state_q == ST_FAST));
        end
    end

    // Next-state logic: recenter, stop, (re)start a run, or advance it
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        div_d   = div_q;
        steps_d = steps_q;
        pos_d   = pos_q;
        if (i_center) begin
            pos_d   = c_origin;
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            div_d   = '0;
            steps_d = '0;
        end else if (w_dir == DIR_NONE) begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            div_d   = '0;
            steps_d = '0;
        end else if (!w_same_run) begin
            // Fresh run: position kept, full period before the first step
            state_d = i_auto ? ST_AUTO : ST_SLOW;
            dir_d   = w_dir;
            div_d   = '0;
            steps_d = '0;
        end else if (div_q == w_div_top) begin
            div_d = '0;
            pos_d = w_pos_step;
            // Clamped steps still count toward acceleration
            if (state_q == ST_SLOW) begin
                if (steps_q == c_accel_top) begin
                    state_d = ST_FAST;
                end
                steps_d = steps_q + STEP_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            div_q   <= '0;
            steps_q <= '0;
            pos_q   <= c_origin;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            pos_q   <= pos_d;
        end
    end

    // Outputs decoded straight from the registers
    always_comb begin
        o_pos    = pos_q;
        o_at_min = (pos_q == c_pos_min);
        o_at_max = (pos_q == c_pos_max);
        o_moving = (state_q != ST_IDLE);
    end

endmodule : paddle_pos_chan
`default_nettype wire

// File: rtl/paddle_pos_multi.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_pos_multi
//  Description : NUM_PADDLES independent paddle position channels sharing
//                one auto-track target coordinate.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_pos_multi
    import pong_pkg::*;
#(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 11,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 380,
    parameter int ORIGIN      = 190,
    parameter int SLOW_DIV    = 250000,
    parameter int FAST_DIV    = 62500,
    parameter int ACCEL_STEPS = 16,
    parameter int AUTO_DIV    = 125000,
    parameter int DEADBAND    = 2
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic [2*NUM_PADDLES-1:0]       i_Switch,
    input  logic [NUM_PADDLES-1:0]         i_Auto,
    input  logic [POS_W-1:0]               i_Target_Pos,
    input  logic [NUM_PADDLES-1:0]         i_Center,
    output logic [NUM_PADDLES*POS_W-1:0]   o_Pos,
    output logic [NUM_PADDLES-1:0]         o_At_Min,
    output logic [NUM_PADDLES-1:0]         o_At_Max,
    output logic [NUM_PADDLES-1:0]         o_Moving
);

    for (genvar ch = 0; ch < NUM_PADDLES; ch++) begin : g_chan
        paddle_pos_chan #(
            .POS_W       (POS_W),
            .POS_MIN     (POS_MIN),
            .POS_MAX     (POS_MAX),
            .ORIGIN      (ORIGIN),
            .SLOW_DIV    (SLOW_DIV),
            .FAST_DIV    (FAST_DIV),
            .ACCEL_STEPS (ACCEL_STEPS),
            .AUTO_DIV    (AUTO_DIV),
            .DEADBAND    (DEADBAND)
        ) u_chan (
            .i_clk    (i_Clock),
            .i_rst_n  (i_Rst_n),
            .i_up     (i_Switch[2*ch]),
            .i_dn     (i_Switch[2*ch+1]),
            .i_auto   (i_Auto[ch]),
            .i_target (i_Target_Pos),
            .i_center (i_Center[ch]),
            .o_pos    (o_Pos[ch*POS_W +: POS_W]),
            .o_at_min (o_At_Min[ch]),
            .o_at_max (o_At_Max[ch]),
            .o_moving (o_Moving[ch])
        );
    end

endmodule : paddle_pos_multi
`default_nettype wire

// File: tb/tb_paddle_pos_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_pos_multi
//  Description : Self-checking bench for paddle_pos_multi with a run-schedule
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_pos_multi;

    localparam int NP     = 2;
    localparam int POS_W  = 11;
    localparam int PMIN   = 0;
    localparam int PMAX   = 10;
    localparam int ORIGIN = 5;
    localparam int SDIV   = 4;
    localparam int FDIV   = 2;
    localparam int ACCEL  = 3;
    localparam int ADIV   = 3;
    localparam int DB     = 1;

    logic                  clk;
    logic                  rst_n;
    logic [2*NP-1:0]       sw;
    logic [NP-1:0]         au;
    logic [POS_W-1:0]      tg;
    logic [NP-1:0]         ce;
    logic [NP*POS_W-1:0]   pos;
    logic [NP-1:0]         amin;
    logic [NP-1:0]         amax;
    logic [NP-1:0]         mov;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is a stretch of cycles with one (mode, dir)
    // request; steps fall at fixed ages measured from the run start.
    int m_pos [NP];
    bit m_act [NP];
    int m_dir [NP];
    bit m_auto[NP];
    int m_age [NP];

    paddle_pos_multi #(
        .NUM_PADDLES (NP),
        .POS_W       (POS_W),
        .POS_MIN     (PMIN),
        .POS_MAX     (PMAX),
        .ORIGIN      (ORIGIN),
        .SLOW_DIV    (SDIV),
        .FAST_DIV    (FDIV),
        .ACCEL_STEPS (ACCEL),
        .AUTO_DIV    (ADIV),
        .DEADBAND    (DB)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Switch     (sw),
        .i_Auto       (au),
        .i_Target_Pos (tg),
        .i_Center     (ce),
        .o_Pos        (pos),
        .o_At_Min     (amin),
        .o_At_Max     (amax),
        .o_Moving     (mov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_step(int age, bit a);
        if (a) return (age % ADIV) == 0;
        if (age <= SDIV * ACCEL) return (age % SDIV) == 0;
        return ((age - SDIV * ACCEL) % FDIV) == 0;
    endfunction

    task automatic model_edge();
        int  d;
        int  t;
        bit  up;
        bit  dn;
        bit  a;
        if (!rst_n) begin
            for (int ch = 0; ch < NP; ch++) begin
                m_pos[ch] = ORIGIN;
                m_act[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < NP; ch++) begin
                up = sw[2*ch];
                dn = sw[2*ch+1];
                a  = au[ch];
                if (ce[ch]) begin
                    m_pos[ch] = ORIGIN;
                    m_act[ch] = 1'b0;
                end else begin
                    if (a) begin
                        t = int'(tg);
                        if (t > PMAX) t = PMAX;
                        if (t < PMIN) t = PMIN;
                        d = (t > m_pos[ch] + DB) ? 1 : ((t + DB < m_pos[ch]) ? -1 : 0);
                    end else begin
                        d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
                    end
                    if (d == 0) begin
                        m_act[ch] = 1'b0;
                    end else if (!m_act[ch] || d != m_dir[ch] || a != m_auto[ch]) begin
                        m_act[ch]  = 1'b1;
                        m_dir[ch]  = d;
                        m_auto[ch] = a;
                        m_age[ch]  = 0;
                    end else begin
                        m_age[ch]++;
                        if (is_step(m_age[ch], a)) begin
                            m_pos[ch] += d;
                            if (m_pos[ch] > PMAX) m_pos[ch] = PMAX;
                            if (m_pos[ch] < PMIN) m_pos[ch] = PMIN;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        logic [POS_W-1:0] exp_p;
        logic [POS_W-1:0] obs_p;
        for (int ch = 0; ch < NP; ch++) begin
            exp_p = POS_W'(m_pos[ch]);
            obs_p = pos[ch*POS_W +: POS_W];
            checks++;
            assert (obs_p === exp_p) else begin
                errors++;
                $error("FAIL pos%0d obs=%0d exp=%0d t=%0t", ch, obs_p, exp_p, $time);
            end
            checks++;
            assert (amin[ch] === (m_pos[ch] == PMIN)) else begin
                errors++;
                $error("FAIL at_min%0d obs=%b exp=%b t=%0t", ch, amin[ch], (m_pos[ch] == PMIN), $time);
            end
            checks++;
            assert (amax[ch] === (m_pos[ch] == PMAX)) else begin
                errors++;
                $error("FAIL at_max%0d obs=%b exp=%b t=%0t", ch, amax[ch], (m_pos[ch] == PMAX), $time);
            end
            checks++;
            assert (mov[ch] === m_act[ch]) else begin
                errors++;
                $error("FAIL moving%0d obs=%b exp=%b t=%0t", ch, mov[ch], m_act[ch], $time);
            end
        end
    endtask

    // Directed expectation against a hand-derived constant
    task automatic expect_val(string tag, int obs, int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int p(int ch);
        return int'(pos[ch*POS_W +: POS_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        au    = '0;
        tg    = '0;
        ce    = '0;
        for (int ch = 0; ch < NP; ch++) begin
            m_pos[ch] = 0; m_act[ch] = 0; m_dir[ch] = 0; m_auto[ch] = 0; m_age[ch] = 0;
        end
        #2;
        tick();
        tick();
        expect_val("reset_pos0", p(0), 5);
        expect_val("reset_pos1", p(1), 5);
        expect_val("reset_moving", int'(mov), 0);
        rst_n = 1'b1;

        // 1: up held through the 4-clock first period, then released
        sw = 4'b0001;
        for (int i = 0; i <= 4; i++) tick();
        expect_val("t1_pos0", p(0), 6);
        expect_val("t1_pos1", p(1), 5);
        sw = 4'b0000;
        tick();
        expect_val("t1_moving0", int'(mov[0]), 0);

        // 2: continuous up from origin, slow then fast, clamped at max
        ce = 2'b01; tick(); ce = 2'b00;
        sw = 4'b0001;
        for (int i = 0; i <= 20; i++) begin
            tick();
            if (i == 12) expect_val("t2_pos_slow", p(0), 8);
            if (i == 14) expect_val("t2_pos_fast1", p(0), 9);
            if (i == 16) expect_val("t2_pos_fast2", p(0), 10);
        end
        expect_val("t2_pos_hold", p(0), 10);
        expect_val("t2_at_max", int'(amax[0]), 1);

        // 5: recenter out of FAST; re-entry waits a fresh slow period
        sw = 4'b0000; tick();
        ce = 2'b01; tick(); ce = 2'b00;
        sw = 4'b0001;
        for (int i = 0; i <= 14; i++) tick();
        expect_val("t5_pos_fast", p(0), 9);
        ce = 2'b01; tick(); ce = 2'b00;
        expect_val("t5_center_pos", p(0), 5);
        expect_val("t5_center_idle", int'(mov[0]), 0);
        for (int i = 0; i < 4; i++) tick();
        expect_val("t5_no_early_step", p(0), 5);
        tick();
        expect_val("t5_slow_step", p(0), 6);
        sw = 4'b0000; tick();

        // 3: ch1 down to the minimum, then both switches
        sw = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) expect_val("t3_pos1_one", p(1), 1);
            if (i == 16) expect_val("t3_pos1_zero", p(1), 0);
        end
        expect_val("t3_pos1_nowrap", p(1), 0);
        expect_val("t3_at_min1", int'(amin[1]), 1);
        sw = 4'b1100;
        for (int i = 0; i < 3; i++) tick();
        expect_val("t3_both_pos1", p(1), 0);
        expect_val("t3_both_idle", int'(mov[1]), 0);
        sw = 4'b0000;

        // 4: auto-track toward 9, then toward an out-of-range target
        ce = 2'b01; tick(); ce = 2'b00;
        au = 2'b01; tg = 11'd9;
        for (int i = 0; i < 15; i++) tick();
        expect_val("t4_deadband_pos", p(0), 8);
        expect_val("t4_deadband_idle", int'(mov[0]), 0);
        tg = 11'd2000;
        for (int i = 0; i < 10; i++) tick();
        expect_val("t4_clamped_target", p(0), 9);

        // 6: reset while both channels move
        au = 2'b00;
        sw = 4'b0110;
        for (int i = 0; i <= 4; i++) tick();
        expect_val("t6_pre_pos0", p(0), 8);
        expect_val("t6_pre_pos1", p(1), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_val("t6_rst_pos0", p(0), 5);
        expect_val("t6_rst_pos1", p(1), 5);
        expect_val("t6_rst_moving", int'(mov), 0);
        for (int i = 0; i < 4; i++) tick();
        expect_val("t6_wait_pos0", p(0), 5);
        tick();
        expect_val("t6_step_pos0", p(0), 4);
        expect_val("t6_step_pos1", p(1), 6);

        // Randomised phase: inputs held for stretches, occasional events
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7, 0) == 0) sw = 4'($urandom);
            if ($urandom_range(15, 0) == 0) au = 2'($urandom);
            if ($urandom_range(11, 0) == 0)
                tg = ($urandom_range(3, 0) == 0) ? 11'($urandom) : 11'($urandom_range(12, 0));
            ce    = ($urandom_range(39, 0) == 0) ? 2'($urandom) : 2'b00;
            rst_n = ($urandom_range(149, 0) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_paddle_pos_multi
`default_nettype wire
